// File: rtl/gfx_pkg.sv
// Shared types and helpers for the renderer-side Wishbone master and its line buffer.
package gfx_pkg;

  localparam int unsigned MDW_DFLT  = 256;
  localparam int unsigned LOG2_LINE = $clog2(MDW_DFLT / 8);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    READ
  } wbm_state_e;

  // Request parked while the posted line is written back.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_WR,
    PEND_RD
  } pend_e;

  function automatic logic fnLineHit(input logic [31:0] adr, input logic [31:0] tag,
                                     input int unsigned lg);
    return (adr >> lg) == (tag >> lg);
  endfunction

endpackage

// File: rtl/gfx_wb_line_buf.sv
// One-line write-posting buffer: line tag, accumulated byte selects and merged line data.
module gfx_wb_line_buf
  import gfx_pkg::*;
#(
  parameter int unsigned MDW = MDW_DFLT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               merge,
  input  logic               clear,
  input  logic [31:0]        adr,
  input  logic [MDW/8-1:0]   sel,
  input  logic [MDW-1:0]     dat,
  output logic               valid,
  output logic [31:0]        tag,
  output logic [MDW/8-1:0]   buf_sel,
  output logic [MDW-1:0]     buf_dat
);

  localparam int unsigned SW = MDW / 8;
  localparam int unsigned LG = $clog2(SW);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << LG) - 32'd1);

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid   <= 1'b0;
      tag     <= '0;
      buf_sel <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
      buf_sel <= '0;
    end else if (merge) begin
      valid   <= 1'b1;
      tag     <= adr & LINE_MASK;
      buf_sel <= buf_sel | sel;
    end
  end

  // NOTE: the line data is deliberately left without reset; only bytes covered by
  // buf_sel are ever driven onto the bus, so its content after reset is irrelevant.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < SW; b++) begin
      if (merge && sel[b]) buf_dat[8*b +: 8] <= dat[8*b +: 8];
    end
  end

endmodule

// File: rtl/gfx_render_wbm.sv
// Renderer pixel/z request responder: posts writes into one line buffer and runs
// Wishbone classic cycles for write-back and line reads.
module gfx_render_wbm
  import gfx_pkg::*;
#(
  parameter int unsigned MDW        = MDW_DFLT,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned FLUSH_IDLE = 15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rd_i,
  input  logic               wr_i,
  input  logic [31:0]        adr_i,
  input  logic [MDW/8-1:0]   sel_i,
  input  logic [MDW-1:0]     dat_i,
  output logic               ack_o,
  output logic               err_o,
  output logic [MDW-1:0]     dat_o,
  input  logic               flush_i,
  output logic               idle_o,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic               m_we_o,
  output logic [31:0]        m_adr_o,
  output logic [MDW/8-1:0]   m_sel_o,
  output logic [MDW-1:0]     m_dat_o,
  input  logic [MDW-1:0]     m_dat_i,
  input  logic               m_ack_i,
  input  logic               m_err_i
);

  localparam int unsigned SW = MDW / 8;
  localparam int unsigned LG = $clog2(SW);
  localparam int unsigned IW = (FLUSH_IDLE > 0) ? $clog2(FLUSH_IDLE + 1) : 1;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << LG) - 32'd1);
  localparam logic [9:0]  TO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(FLUSH_IDLE);

  wbm_state_e       state_q, state_d;
  pend_e            pend_q, pend_d;
  logic             flush_req_q, flush_req_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [9:0]       to_cnt_q, to_cnt_d;
  logic [31:0]      req_adr_q, req_adr_d;
  logic             ack_d, err_d;
  logic [MDW-1:0]   dat_d;

  logic             buf_merge, buf_clear, buf_valid;
  logic [31:0]      buf_tag;
  logic [SW-1:0]    buf_sel;
  logic [MDW-1:0]   buf_dat;

  logic             hit, bus_ok, bus_err, auto_flush;

  gfx_wb_line_buf #(.MDW(MDW)) u_line_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .merge   (buf_merge),
    .clear   (buf_clear),
    .adr     (adr_i),
    .sel     (sel_i),
    .dat     (dat_i),
    .valid   (buf_valid),
    .tag     (buf_tag),
    .buf_sel (buf_sel),
    .buf_dat (buf_dat)
  );

  assign hit        = fnLineHit(adr_i, buf_tag, LG);
  // Error beats ack; an ack arriving in the last allowed cycle still completes normally.
  assign bus_err    = m_err_i || ((to_cnt_q == TO_LAST) && !m_ack_i);
  assign bus_ok     = m_ack_i && !m_err_i;
  assign auto_flush = (FLUSH_IDLE != 0) && buf_valid && (idle_cnt_q == IDLE_LIM);

  // NOTE: every signal written here gets its default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    flush_req_d = flush_req_q | flush_i;
    idle_cnt_d  = idle_cnt_q;
    to_cnt_d    = to_cnt_q + 10'd1;
    req_adr_d   = req_adr_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = dat_o;
    buf_merge   = 1'b0;
    buf_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (rd_i || wr_i || flush_i) idle_cnt_d = '0;
        else if (buf_valid && idle_cnt_q != IDLE_LIM) idle_cnt_d = idle_cnt_q + 1'b1;

        // The cycle after ack_o still shows the finished request: accept nothing then.
        if (!ack_o) begin
          if (wr_i) begin
            req_adr_d = adr_i & LINE_MASK;
            if (!buf_valid || hit) begin
              buf_merge = 1'b1;
              ack_d     = 1'b1;
            end else begin
              state_d = FLUSH;
              pend_d  = PEND_WR;
            end
          end else if (rd_i) begin
            req_adr_d = adr_i & LINE_MASK;
            if (buf_valid) begin
              state_d = FLUSH;
              pend_d  = PEND_RD;
            end else begin
              state_d = READ;
            end
          end else if (flush_req_q || flush_i || auto_flush) begin
            flush_req_d = 1'b0;
            idle_cnt_d  = '0;
            if (buf_valid) begin
              state_d = FLUSH;
              pend_d  = PEND_NONE;
            end
          end
        end
      end

      FLUSH: begin
        if (bus_err) begin
          buf_clear = 1'b1;
          if (pend_q != PEND_NONE) begin
            ack_d = 1'b1;
            err_d = 1'b1;
            dat_d = '0;
          end
          pend_d  = PEND_NONE;
          state_d = IDLE;
        end else if (bus_ok) begin
          buf_clear = 1'b1;
          pend_d    = PEND_NONE;
          if (pend_q == PEND_RD) begin
            state_d  = READ;
            to_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      READ: begin
        if (bus_err) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          dat_d   = '0;
          state_d = IDLE;
        end else if (bus_ok) begin
          ack_d   = 1'b1;
          dat_d   = m_dat_i;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pend_q      <= PEND_NONE;
      flush_req_q <= 1'b0;
      idle_cnt_q  <= '0;
      to_cnt_q    <= '0;
      req_adr_q   <= '0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      dat_o       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      flush_req_q <= flush_req_d;
      idle_cnt_q  <= idle_cnt_d;
      to_cnt_q    <= to_cnt_d;
      req_adr_q   <= req_adr_d;
      ack_o       <= ack_d;
      err_o       <= err_d;
      dat_o       <= dat_d;
    end
  end

  // Bus controls decode straight from the state register, so reset drops the cycle at once.
  always_comb begin
    m_cyc_o = (state_q != IDLE);
    m_stb_o = (state_q != IDLE);
    m_we_o  = (state_q == FLUSH);
    m_adr_o = '0;
    m_sel_o = '0;
    m_dat_o = '0;
    if (state_q == FLUSH) begin
      m_adr_o = buf_tag;
      m_sel_o = buf_sel;
      m_dat_o = buf_dat;
    end else if (state_q == READ) begin
      m_adr_o = req_adr_q;
      m_sel_o = '1;
    end
  end

  assign idle_o = (state_q == IDLE) && !buf_valid && !rd_i && !wr_i;

endmodule

// File: doc/gfx_render_wbm.md
Name: gfx_render_wbm

Overview:
- Memory-side responder for the renderer's pixel/z request interface (read/write strobe held until ack, line address, byte select, MDW-bit line data).
- Converts requests into Wishbone classic master cycles on the frame-buffer bus.
- Holds a one-line write-posting buffer, so pixel and z writes to the same line merge and are acknowledged without waiting on the bus.
- Sits between the renderer and the memory arbiter.

Parameters:
- MDW, 256, line data width in bits; the select width is MDW/8.
- TIMEOUT, 1023, bus cycles allowed before a pending m_ack_i is abandoned; 10-bit counter.
- FLUSH_IDLE, 15, idle cycles before a valid posted line is flushed automatically; 0 disables auto-flush.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- rd_i  in  1  read request, held until ack_o
- wr_i  in  1  write request, held until ack_o
- adr_i  in  32  byte address; bits below log2(MDW/8) are ignored
- sel_i  in  MDW/8  byte enables for a write
- dat_i  in  MDW  write line data
- ack_o  out  1  one-cycle request completion pulse
- err_o  out  1  pulses together with ack_o when the bus errors or times out
- dat_o  out  MDW  read data, valid while ack_o is high
- flush_i  in  1  force write-back of the posted line
- idle_o  out  1  high when in IDLE, buffer empty and no request pending
- m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone master controls
- m_adr_o  out  32  line-aligned address; low bits are 0
- m_sel_o  out  MDW/8  byte selects
- m_dat_o  out  MDW  write data
- m_dat_i  in  MDW  read data
- m_ack_i, m_err_i  in  1 each  Wishbone termination

Behaviour:
- Reset: asynchronous, active-low; the clock and the single reset are fixed.
  - All outputs go to 0 except idle_o, which goes to 1.
  - Buffer valid, pending flags and counters clear.
  - Reset mid-cycle drops m_cyc_o immediately and discards posted data.
- Acceptance rule: a request is accepted only in IDLE and only when ack_o is 0. The cycle after an ack still shows the old request and must not be re-accepted.
- Line hit: adr_i[31:log2(MDW/8)] equals the buffer tag.
- State IDLE:
  - Write, buffer empty or hit: merge. For each byte with sel_i set, buffer data takes dat_i; the buffer sel ORs in sel_i; valid=1; tag=line. Registered ack_o on the next cycle (latency 1).
  - Write, buffer valid and miss: go to FLUSH with the write pending.
  - Read, buffer valid (any address, preserves ordering): go to FLUSH with the read pending.
  - Read, buffer empty: go to READ.
  - flush_i, or the idle counter reaching FLUSH_IDLE with the buffer valid: go to FLUSH with nothing pending.
  - The idle counter resets on any request or flush.
- State FLUSH:
  - Drive cyc=stb=we=1, adr=tag, sel=buffer sel, dat=buffer data.
  - On m_ack_i: drop cyc/stb, valid=0. Next state is IDLE (pending write merges there as an empty-buffer write) or READ (pending read).
  - On m_err_i or timeout: valid=0, ack_o and err_o pulse if a request is pending, go to IDLE.
- State READ:
  - Drive cyc=stb=1, we=0, sel all ones, adr=line.
  - On m_ack_i: dat_o<=m_dat_i, ack_o pulse, go to IDLE.
  - On m_err_i or timeout: dat_o<=0, ack_o and err_o pulse, go to IDLE.
- Timeout: the counter restarts on entering FLUSH or READ. Reaching TIMEOUT counts as an error.
- Simultaneous m_ack_i and m_err_i: the error wins.
- Simultaneous rd_i and wr_i: the write is taken first; the read stays held by the requester.
- flush_i while not in IDLE is remembered and serviced on return to IDLE.
- Only one bus cycle is outstanding at a time; m_stb_o deasserts in the cycle after termination.

Decomposition:
- gfx_pkg:
  - wbm_state_e {IDLE, FLUSH, READ}.
  - Line-offset constant LOG2_LINE = $clog2(MDW/8).
  - Function fnLineHit.
- Sub-module gfx_wb_line_buf: tag/data/sel registers plus byte-merge logic, with merge and clear strobes.
- The FSM and timeout counter stay in gfx_render_wbm.

Test Plan:
- Write 0x1000 sel=0x0000000F, then write 0x1010 sel=0x000F0000 → each is acked 1 cycle after acceptance with no bus cycle; flush_i → one bus write to 0x1000 with sel=0x000F000F and merged data.
- Buffer holds 0x1000; write to 0x2000 → bus write 0x1000 first, then 0x2000 is merged; ack_o arrives only after the m_ack_i for 0x1000.
- Read 0x3000 with the buffer valid at 0x1000 → flush write, then a read with sel=FFFFFFFF; dat_o=m_dat_i in the ack_o cycle; renderer requests held across two cycles are accepted once.
- Read with m_ack_i never asserted, TIMEOUT=1023 → m_cyc_o drops after 1023 cycles; ack_o=err_o=1 for one cycle; dat_o=0.
- m_err_i during a flush with a pending write → valid=0, ack_o+err_o pulse; a subsequent write merges into the empty buffer.
- rst_ni low mid-READ → m_cyc_o=0 asynchronously; idle_o=1; a later write is acked after 1 cycle with no stale flush.
